// File: rtl/spike_sampler_pkg.sv
// rtl/spike_sampler_pkg.sv - shared constants, FSM encoding and LFSR step for the spike sampler
//
// Purpose: definitions shared by spike_sampler and lfsr16.
//   q08_width          probability width reused from the sigmoid stage (Q0.8)
//   lfsr_taps          Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
//   lfsr_default_seed  default LFSR reset value (must be nonzero)
//   state_t            sampler FSM encoding
//   lfsr_step()        one advance of the 16-bit Galois LFSR
package spike_sampler_pkg;

   localparam int          q08_width         = 8;
   localparam logic [15:0] lfsr_taps         = 16'hB400;
   localparam logic [15:0] lfsr_default_seed = 16'hACE1;

   typedef enum logic [1:0] {
      st_idle   = 2'd0,
      st_sample = 2'd1,
      st_scan   = 2'd2,
      st_done   = 2'd3
   } state_t;

   // Right shift; the bit falling out of the LSB folds the tap mask back in.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) begin
         n = n ^ lfsr_taps;
      end
      return n;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR random source
//
// Purpose: uniform pseudo-random source, advanced once per enabled cycle.
//   Also intended as the hidden-layer random source.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, loads seed
//   en     in   advance the register this cycle
//   seed   in   reset value (tie to a constant, must be nonzero)
//   q      out  current LFSR state
module lfsr16
   import spike_sampler_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= seed;
      end else if (en) begin
         q <= lfsr_step(q);
      end
   end

endmodule

// File: rtl/spike_sampler.sv
// rtl/spike_sampler.sv - Bernoulli spike sampler and per-class spike-count scorer
//
// Purpose: samples each Q0.8 probability against an LFSR draw, accumulates
//   spikes per class over num_iter iterations, then scans the counters and
//   reports the winning class (ties go to the lowest index).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           frame start pulse, honoured only in IDLE
//   p_valid, p      probability input handshake (valid side)
//   p_ready         input accepted while in SAMPLE
//   spike_valid     one-cycle pulse per accepted sample
//   spike           sampled spike bit
//   spike_idx       class index of that sample
//   busy            high outside IDLE
//   done            one-cycle pulse when class_out/class_count update
//   class_out       winning class, held until next start
//   class_count     spike count of the winning class
module spike_sampler
   import spike_sampler_pkg::*;
#(
   parameter int          bitlength = q08_width,
   parameter int          num_class = 10,
   parameter int          num_iter  = 100,
   parameter int          cnt_width = 7,
   parameter int          idx_width = 4,
   parameter logic [15:0] lfsr_seed = lfsr_default_seed
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 p_valid,
   input  logic [bitlength-1:0] p,
   output logic                 p_ready,
   output logic                 spike_valid,
   output logic                 spike,
   output logic [idx_width-1:0] spike_idx,
   output logic                 busy,
   output logic                 done,
   output logic [idx_width-1:0] class_out,
   output logic [cnt_width-1:0] class_count
);

   localparam int                   iter_width = (num_iter > 1) ? $clog2(num_iter) : 1;
   localparam logic [idx_width-1:0] last_idx   = idx_width'(num_class - 1);
   localparam logic [iter_width-1:0] last_iter = iter_width'(num_iter - 1);
   localparam logic [cnt_width-1:0] cnt_max    = '1;

   state_t                state, state_nxt;
   logic [idx_width-1:0]  idx;
   logic [iter_width-1:0] iter;
   logic [idx_width-1:0]  scan_idx;
   logic [idx_width-1:0]  best_idx;
   logic [cnt_width-1:0]  best_cnt;
   // Register array, not RAM: SCAN reads it combinationally by index.
   logic [cnt_width-1:0]  count [num_class];

   logic [15:0]           lfsr_q;
   logic [bitlength-1:0]  r;
   logic                  unused_lfsr_hi;
   logic                  accept;
   logic                  start_ok;
   logic                  sample_spike;
   logic                  last_sample;
   logic                  scan_last;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .seed  (lfsr_seed),
      .q     (lfsr_q)
   );

   // Draw is taken from the low bits before this cycle's advance.
   assign r              = lfsr_q[bitlength-1:0];
   assign unused_lfsr_hi = ^lfsr_q[15:bitlength];

   assign p_ready      = (state == st_sample);
   assign busy         = (state != st_idle);
   assign accept       = p_ready && p_valid;
   assign sample_spike = (r < p);
   assign last_sample  = (idx == last_idx) && (iter == last_iter);
   assign scan_last    = (scan_idx == last_idx);
   // done is high in the first IDLE cycle; blocking start there makes a
   // start coincident with done ignored.
   assign start_ok     = (state == st_idle) && start && !done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= st_idle;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         st_idle:   if (start_ok) state_nxt = st_sample;
         st_sample: if (accept && last_sample) state_nxt = st_scan;
         st_scan:   if (scan_last) state_nxt = st_done;
         st_done:   state_nxt = st_idle;
         default:   state_nxt = st_idle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '0;
         iter        <= '0;
         scan_idx    <= '0;
         best_idx    <= '0;
         best_cnt    <= '0;
         spike_valid <= 1'b0;
         spike       <= 1'b0;
         spike_idx   <= '0;
         done        <= 1'b0;
         class_out   <= '0;
         class_count <= '0;
         for (int i = 0; i < num_class; i++) begin
            count[i] <= '0;
         end
      end else begin
         spike_valid <= 1'b0;
         done        <= 1'b0;

         if (start_ok) begin
            idx         <= '0;
            iter        <= '0;
            scan_idx    <= '0;
            best_idx    <= '0;
            best_cnt    <= '0;
            class_out   <= '0;
            class_count <= '0;
            for (int i = 0; i < num_class; i++) begin
               count[i] <= '0;
            end
         end

         if (accept) begin
            spike_valid <= 1'b1;
            spike       <= sample_spike;
            spike_idx   <= idx;
            if (sample_spike && (count[idx] != cnt_max)) begin
               count[idx] <= count[idx] + cnt_width'(1);
            end
            if (idx == last_idx) begin
               idx  <= '0;
               iter <= iter + iter_width'(1);
            end else begin
               idx <= idx + idx_width'(1);
            end
         end

         // Strict greater-than keeps the lowest index on ties.
         if (state == st_scan) begin
            if (count[scan_idx] > best_cnt) begin
               best_cnt <= count[scan_idx];
               best_idx <= scan_idx;
            end
            scan_idx <= scan_last ? '0 : scan_idx + idx_width'(1);
         end

         if (state == st_done) begin
            done        <= 1'b1;
            class_out   <= best_idx;
            class_count <= best_cnt;
         end
      end
   end

endmodule
